// File: rtl/toy_ldq_credit_rx.sv
// Dual-lane load queue between the LSU issue buffer and the memory pipe, with credit return.
// Define TOY_LDQ_CREDIT_BATCH_EN to coalesce credits in batches of CREDIT_BATCH; otherwise one credit per pop.
package lsu_pkg;
  typedef struct packed {
    logic [11:0] addr;
    logic [3:0]  tag;
  } ldu_pld_t;
endpackage

module toy_ldq_credit_rx #(
  parameter int DEPTH        = 8,
  parameter int CREDIT_BATCH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              v_s_ldu_vld,
  input  lsu_pkg::ldu_pld_t [1:0] v_s_ldu_pld,
  output logic [1:0]              v_ldq_rdy,
  output logic                    m_mem_vld,
  output lsu_pkg::ldu_pld_t       m_mem_pld,
  input  logic                    m_mem_rdy,
  input  logic                    cancel_en,
  output logic                    ldu_credit_en,
  output logic [3:0]              ldu_credit_num,
  output logic [$clog2(DEPTH):0]  ldq_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
`ifdef TOY_LDQ_CREDIT_BATCH_EN
  localparam int BATCH_EFF = CREDIT_BATCH;
`else
  // CREDIT_BATCH is ignored: with a threshold of one every pop is its own batch.
  localparam int BATCH_EFF = 1 + 0 * CREDIT_BATCH;
`endif

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t            r_state;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_cnt;
  logic [3:0]        r_credit_acc;
  lsu_pkg::ldu_pld_t r_mem [DEPTH];

  logic          w_full;
  logic [PW-1:0] w_free;
  logic          w_push0;
  logic          w_push1;
  logic          w_pop;
  logic [PW-1:0] w_push_n;
  logic [PW-1:0] w_wr_ptr_p1;
  logic [3:0]    w_credit_sum;

  assign w_full = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_free = DEPTH_P - r_cnt;

  assign v_ldq_rdy[0] = (r_state == ST_RUN) && !w_full;
  assign v_ldq_rdy[1] = (r_state == ST_RUN) && (w_free >= PW'(2));

  // Lane1 rides only behind an accepted lane0 so the queue never holds a gap.
  assign w_push0     = v_s_ldu_vld[0] && v_ldq_rdy[0] && !cancel_en;
  assign w_push1     = w_push0 && v_s_ldu_vld[1] && v_ldq_rdy[1];
  assign w_push_n    = PW'(w_push0) + PW'(w_push1);
  assign w_wr_ptr_p1 = r_wr_ptr + PW'(1);

  assign m_mem_vld = (r_cnt != '0) && (r_state == ST_RUN) && !cancel_en;
  assign m_mem_pld = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop     = m_mem_vld && m_mem_rdy;
  assign ldq_cnt   = r_cnt;

  assign w_credit_sum = r_credit_acc + 4'(w_pop);

  // NOTE: entry storage has no reset; occupancy is tracked by the pointers, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (w_push0) r_mem[r_wr_ptr[AW-1:0]]    <= v_s_ldu_pld[0];
    if (w_push1) r_mem[w_wr_ptr_p1[AW-1:0]] <= v_s_ldu_pld[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= cancel_en ? ST_FLUSH : ST_RUN;
      if (cancel_en) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + w_push_n;
        r_rd_ptr <= r_rd_ptr + PW'(w_pop);
        r_cnt    <= r_cnt + w_push_n - PW'(w_pop);
      end
    end
  end

  // Credits flush on reaching the batch size, or as soon as the pop stream goes quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit_acc   <= '0;
      ldu_credit_en  <= 1'b0;
      ldu_credit_num <= '0;
    end else if (cancel_en) begin
      r_credit_acc   <= '0;
      ldu_credit_en  <= 1'b0;
      ldu_credit_num <= '0;
    end else if ((w_credit_sum >= 4'(BATCH_EFF)) || ((w_credit_sum != '0) && !w_pop)) begin
      r_credit_acc   <= '0;
      ldu_credit_en  <= 1'b1;
      ldu_credit_num <= w_credit_sum;
    end else begin
      r_credit_acc   <= w_credit_sum;
      ldu_credit_en  <= 1'b0;
    end
  end
endmodule
